fft_input_bitrev_loader: RTL and testbench

//  Upstream feeder for the 32-point FFT stage chain. Accepts complex samples

---
 rtl/fft_input_bitrev_loader.sv | 126 ++++++++++++
 tb/tb_fft_input_bitrev_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_bitrev_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_bitrev_loader
// Description : Serial-to-frame loader for a 32-point FFT. Complex samples
//               arrive one per cycle (valid/ready) and are written at their
//               bit-reversed slot. Two banks ping-pong: one fills while the
//               other is presented as flat buses to the FFT stages, which
//               take it with frame_valid/frame_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_bitrev_loader #(
  parameter int DATA_W   = 10,
  parameter int N_POINTS = 32,
  parameter int LOG2N    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_re,
  input  logic [DATA_W-1:0]          in_im,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [N_POINTS*DATA_W-1:0] out_real,
  output logic [N_POINTS*DATA_W-1:0] out_imag,
  output logic                       sof_resync
);

  localparam logic [LOG2N-1:0] c_last_idx = LOG2N'(N_POINTS - 1);

  // Mirror the index bits: sample k lands in slot bitrev(k).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

  // Bank state: one full flag per bank, write/read bank pointers, fill count.
  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic             r_sof_resync;

  // Sample storage, indexed [bank][slot].
  logic [DATA_W-1:0] r_re [2][N_POINTS];
  logic [DATA_W-1:0] r_im [2][N_POINTS];

  logic             w_accept;
  logic             w_restart;
  logic [LOG2N-1:0] w_k;
  logic [LOG2N-1:0] w_slot;
  logic             w_last;
  logic             w_consume;

  // The write bank is only ever full when both banks are, so this is the
  // back-pressure condition; it depends on registers only.
  assign in_ready    = ~r_full[r_wr_bank];
  assign frame_valid = r_full[r_rd_bank];
  assign sof_resync  = r_sof_resync;

  assign w_accept  = in_valid & in_ready;
  // An SOF arriving mid-frame drops the partial frame and restarts at k=0.
  assign w_restart = w_accept & in_sof & (r_wr_cnt != '0);
  assign w_k       = w_restart ? '0 : r_wr_cnt;
  assign w_slot    = bitrev(w_k);
  assign w_last    = w_accept & (w_k == c_last_idx);
  assign w_consume = r_full[r_rd_bank] & frame_ready;

  // Bank bookkeeping. A last-sample write and a consume never target the
  // same bank (one needs it empty, the other full), so both can land together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full       <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_cnt     <= '0;
      r_sof_resync <= 1'b0;
    end else begin
      r_sof_resync <= w_restart;
      if (w_accept) begin
        r_wr_cnt <= w_last ? '0 : (w_k + 1'b1);
      end
      if (w_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_consume) begin
        r_rd_bank <= ~r_rd_bank;
      end
      for (int b = 0; b < 2; b++) begin
        if (w_last && (r_wr_bank == 1'(b))) begin
          r_full[b] <= 1'b1;
        end else if (w_consume && (r_rd_bank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
    end
  end

  // Sample storage: accepted data written unmodified at its bit-reversed slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < N_POINTS; j++) begin
          r_re[b][j] <= '0;
          r_im[b][j] <= '0;
        end
      end
    end else if (w_accept) begin
      r_re[r_wr_bank][w_slot] <= in_re;
      r_im[r_wr_bank][w_slot] <= in_im;
    end
  end

  // Present the read bank as flat buses, slot j at [j*DATA_W +: DATA_W].
  for (genvar j = 0; j < N_POINTS; j++) begin : g_out
    assign out_real[j*DATA_W +: DATA_W] = r_re[r_rd_bank][j];
    assign out_imag[j*DATA_W +: DATA_W] = r_im[r_rd_bank][j];
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_input_bitrev_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_bitrev_loader
// Description : Self-checking bench for fft_input_bitrev_loader. A reference
//               model rebuilds each frame in slot order and queues it; the
//               queue head is compared against the DUT buses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_bitrev_loader;

  localparam int DATA_W   = 10;
  localparam int N_POINTS = 32;
  localparam int LOG2N    = 5;
  localparam int FW       = N_POINTS * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic              frame_ready = 1'b0;
  logic [DATA_W-1:0] in_re = '0;
  logic [DATA_W-1:0] in_im = '0;
  logic              in_ready;
  logic              frame_valid;
  logic              sof_resync;
  logic [FW-1:0]     out_real;
  logic [FW-1:0]     out_imag;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [FW-1:0] q_re[$];
  logic [FW-1:0] q_im[$];
  logic [FW-1:0] m_fre;
  logic [FW-1:0] m_fim;
  int            m_cnt;
  bit            exp_resync;

  always #5 clk = ~clk;

  fft_input_bitrev_loader #(
    .DATA_W  (DATA_W),
    .N_POINTS(N_POINTS),
    .LOG2N   (LOG2N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_re      (in_re),
    .in_im      (in_im),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .sof_resync (sof_resync)
  );

  // Bit reversal computed arithmetically (LSB-first rebuild).
  function automatic int rev(input int k);
    int r;
    int x;
    r = 0;
    x = k;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    q_re.delete();
    q_im.delete();
    m_cnt      = 0;
    exp_resync = 1'b0;
    m_fre      = '0;
    m_fim      = '0;
  endtask

  // Advance one clock; update the model from the handshakes seen before the edge.
  task automatic cycle();
    bit                acc;
    bit                con;
    bit                sof;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    acc = in_valid && in_ready;
    con = frame_valid && frame_ready;
    sof = in_sof;
    re  = in_re;
    im  = in_im;
    @(posedge clk);
    #1;
    exp_resync = 1'b0;
    if (con && q_re.size() != 0) begin
      void'(q_re.pop_front());
      void'(q_im.pop_front());
    end
    if (acc) begin
      if (sof && m_cnt != 0) begin
        m_cnt      = 0;
        exp_resync = 1'b1;
      end
      m_fre[rev(m_cnt)*DATA_W +: DATA_W] = re;
      m_fim[rev(m_cnt)*DATA_W +: DATA_W] = im;
      m_cnt++;
      if (m_cnt == N_POINTS) begin
        q_re.push_back(m_fre);
        q_im.push_back(m_fim);
        m_cnt = 0;
      end
    end
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                      input logic sof);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_sof   = sof;
    while (in_ready !== 1'b1) begin
      if (waited >= 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        return;
      end
      cycle();
      waited++;
    end
    cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    n_tests++; if (out_real !== '0) begin n_fail++; $display("FAIL reset_out_real: got %h want 0", out_real); end
    n_tests++; if (out_imag !== '0) begin n_fail++; $display("FAIL reset_out_imag: got %h want 0", out_imag); end
    n_tests++; if (sof_resync !== 1'b0) begin n_fail++; $display("FAIL reset_sof_resync: got %b want 0", sof_resync); end
    rst = 1'b1;
    model_reset();
    cycle();
  endtask

  task automatic test_single_frame();
    frame_ready = 1'b0;
    for (int k = 0; k < N_POINTS; k++) begin
      if (k == N_POINTS - 1) begin
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", frame_valid); end
      end
      send(DATA_W'(k), DATA_W'(-k), k == 0);
      if (k == 0) begin
        n_tests++; if (sof_resync !== 1'b0) begin n_fail++; $display("FAIL single_sof_noop: got %b want 0", sof_resync); end
      end
    end
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_frame_valid: got %b want 1", frame_valid); end
    n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL single_out_real: got %h want %h", out_real, m_fre); end
    n_tests++; if (q_im.size() == 0 || out_imag !== q_im[0]) begin n_fail++; $display("FAIL single_out_imag: got %h want %h", out_imag, m_fim); end
    n_tests++; if (out_real[16*DATA_W +: DATA_W] !== 10'd1) begin n_fail++; $display("FAIL single_slot16: got %0d want 1", out_real[16*DATA_W +: DATA_W]); end
    n_tests++; if (out_real[24*DATA_W +: DATA_W] !== 10'd3) begin n_fail++; $display("FAIL single_slot24: got %0d want 3", out_real[24*DATA_W +: DATA_W]); end
    n_tests++; if (out_real[31*DATA_W +: DATA_W] !== 10'd31) begin n_fail++; $display("FAIL single_slot31_re: got %0d want 31", out_real[31*DATA_W +: DATA_W]); end
    n_tests++; if (out_imag[31*DATA_W +: DATA_W] !== 10'h3E1) begin n_fail++; $display("FAIL single_slot31_im: got %h want 3e1", out_imag[31*DATA_W +: DATA_W]); end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got %b want 0", frame_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] held_re;
    logic [DATA_W-1:0] held_im;
    frame_ready = 1'b0;
    for (int i = 0; i < 2 * N_POINTS; i++) begin
      send(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_low: got %b want 0", in_ready); end
    // Hold a pending sample while both banks are full: it must not be taken.
    held_re  = DATA_W'($urandom);
    held_im  = DATA_W'($urandom);
    in_valid = 1'b1;
    in_re    = held_re;
    in_im    = held_im;
    repeat (3) cycle();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", in_ready); end
    n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL b2b_frame1: got %h want frame1", out_real); end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_frame2_valid: got %b want 1", frame_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_back: got %b want 1", in_ready); end
    n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL b2b_frame2: got %h want frame2", out_real); end
    send(held_re, held_im, 1'b0);
    for (int i = 1; i < N_POINTS; i++) begin
      send(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    end
    for (int f = 0; f < 2; f++) begin
      n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_valid%0d: got %b want 1", f, frame_valid); end
      n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL b2b_drain_re%0d: got %h want queued", f, out_real); end
      n_tests++; if (q_im.size() == 0 || out_imag !== q_im[0]) begin n_fail++; $display("FAIL b2b_drain_im%0d: got %h want queued", f, out_imag); end
      frame_ready = 1'b1;
      cycle();
      frame_ready = 1'b0;
    end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", frame_valid); end
  endtask

  task automatic test_throughput();
    int            stalls;
    int            nframes;
    logic [FW-1:0] ones;
    ones        = {N_POINTS{10'd1}};
    stalls      = 0;
    nframes     = 0;
    frame_ready = 1'b1;
    for (int c = 0; c < 2 * N_POINTS + 2; c++) begin
      if (c < 2 * N_POINTS) begin
        in_valid = 1'b1;
        in_re    = 10'd1;
        in_im    = 10'd1;
        if (in_ready !== 1'b1) stalls++;
      end else begin
        in_valid = 1'b0;
      end
      if (frame_valid === 1'b1) begin
        nframes++;
        n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL tput_model_re: got %h want queued", out_real); end
        n_tests++; if (out_real !== ones || out_imag !== ones) begin n_fail++; $display("FAIL tput_const: got %h/%h want all 1", out_real, out_imag); end
      end
      cycle();
    end
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL tput_stalls: got %0d want 0", stalls); end
    n_tests++; if (nframes != 2) begin n_fail++; $display("FAIL tput_frames: got %0d want 2", nframes); end
  endtask

  task automatic test_sof_resync();
    int stale;
    frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(DATA_W'(100 + i), DATA_W'(i), i == 0);
      if (i == 0) begin
        n_tests++; if (sof_resync !== 1'b0) begin n_fail++; $display("FAIL sof_noop_pulse: got %b want 0", sof_resync); end
      end
    end
    send(10'd7, 10'd0, 1'b1);
    n_tests++; if (sof_resync !== 1'b1 || exp_resync !== 1'b1) begin n_fail++; $display("FAIL sof_pulse: got %b want 1", sof_resync); end
    cycle();
    n_tests++; if (sof_resync !== 1'b0) begin n_fail++; $display("FAIL sof_pulse_width: got %b want 0", sof_resync); end
    for (int i = 1; i < N_POINTS; i++) begin
      send(DATA_W'(200 + i), DATA_W'(i), 1'b0);
    end
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL sof_frame_valid: got %b want 1", frame_valid); end
    n_tests++; if (out_real[DATA_W-1:0] !== 10'd7) begin n_fail++; $display("FAIL sof_slot0: got %0d want 7", out_real[DATA_W-1:0]); end
    n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL sof_frame: got %h want queued", out_real); end
    stale = 0;
    for (int j = 0; j < N_POINTS; j++) begin
      if (out_real[j*DATA_W +: DATA_W] >= 10'd100 && out_real[j*DATA_W +: DATA_W] <= 10'd109) stale++;
    end
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL sof_stale: got %0d stale slots want 0", stale); end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
  endtask

  task automatic test_simul_consume();
    frame_ready = 1'b0;
    for (int i = 0; i < 2 * N_POINTS - 1; i++) begin
      send(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    end
    n_tests++; if (frame_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_pre: got valid=%b ready=%b want 1/1", frame_valid, in_ready); end
    n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL simul_frameA: got %h want queued", out_real); end
    frame_ready = 1'b1;
    send(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    frame_ready = 1'b0;
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %b want 1", frame_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_in_ready: got %b want 1", in_ready); end
    n_tests++; if (q_re.size() != 1 || out_real !== q_re[0] || out_imag !== q_im[0]) begin n_fail++; $display("FAIL simul_frameB: got %h want queued", out_real); end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained: got %b want 0", frame_valid); end
  endtask

  task automatic test_reset_midframe();
    frame_ready = 1'b0;
    for (int i = 0; i < N_POINTS + 20; i++) begin
      send(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", frame_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_real !== '0 || out_imag !== '0) begin n_fail++; $display("FAIL rstmid_out: got %h want 0", out_real); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N_POINTS; k++) begin
      send(DATA_W'(k + 50), DATA_W'(k), 1'b0);
    end
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid: got %b want 1", frame_valid); end
    n_tests++; if (out_real[16*DATA_W +: DATA_W] !== 10'd51) begin n_fail++; $display("FAIL rstmid_slot16: got %0d want 51", out_real[16*DATA_W +: DATA_W]); end
    n_tests++; if (q_re.size() == 0 || out_real !== q_re[0]) begin n_fail++; $display("FAIL rstmid_frame: got %h want queued", out_real); end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_throughput();
    test_sof_resync();
    test_simul_consume();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
